// File: rtl/e203_itcm_arb.sv
`default_nettype none
// ============================================================================
// Module   : e203_itcm_arb
// Purpose  : Two-port (IFU / LSU) arbiter in front of a single-port ITCM RAM.
//            One RAM access in flight at a time, LSU priority with a bounded
//            IFU starvation window, and an idle-driven RAM light-sleep.
// Revision : 1.0 - initial release
// ============================================================================
module e203_itcm_arb #(
    parameter int AW      = 13,
    parameter int DW      = 64,
    parameter int MW      = 8,
    parameter int IDLE_LS = 16,
    parameter int STARVE  = 4
) (
    input  logic          clk,
    input  logic          rst,
    // IFU port (read only)
    input  logic          ifu_cmd_valid,
    output logic          ifu_cmd_ready,
    input  logic [AW-1:0] ifu_cmd_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    // LSU port (read / write)
    input  logic          lsu_cmd_valid,
    output logic          lsu_cmd_ready,
    input  logic          lsu_cmd_read,
    input  logic [AW-1:0] lsu_cmd_addr,
    input  logic [DW-1:0] lsu_cmd_wdata,
    input  logic [MW-1:0] lsu_cmd_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    // RAM side
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          arb_busy
);

    // Counter widths sized to hold their saturation values.
    localparam int c_IW = (IDLE_LS < 1) ? 1 : $clog2(IDLE_LS + 1);
    localparam int c_SW = (STARVE  < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [c_IW-1:0] c_IDLE_MAX   = c_IW'(IDLE_LS);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE);

    logic            r_pend;      // a response is owed to one port
    logic            r_pend_lsu;  // owner of the pending response
    logic            r_pend_wr;   // pending response is an LSU write (rdata 0)
    logic            r_first;     // first response cycle: data comes straight from RAM
    logic            r_wake;      // wake-up cycle after light-sleep, grants blocked
    logic [DW-1:0]   r_hold;
    logic [c_SW-1:0] r_starve;
    logic [c_IW-1:0] r_idle;

    logic          w_ls;
    logic          w_rsp_hs;
    logic          w_can;
    logic          w_force_ifu;
    logic          w_gnt_lsu;
    logic          w_gnt_ifu;
    logic          w_gnt;
    logic          w_any_valid;
    logic          w_idle_cyc;
    logic [DW-1:0] w_rdata;

    assign w_ls        = (r_idle == c_IDLE_MAX);
    assign w_any_valid = ifu_cmd_valid | lsu_cmd_valid;
    assign w_rsp_hs    = r_pend & (r_pend_lsu ? lsu_rsp_ready : ifu_rsp_ready);
    // Grant slot exists when awake and the previous response is gone or leaving now.
    assign w_can       = ~rst & ~w_ls & ~r_wake & (~r_pend | w_rsp_hs);
    assign w_force_ifu = ifu_cmd_valid & (r_starve >= c_STARVE_MAX);
    assign w_gnt_lsu   = w_can & lsu_cmd_valid & ~w_force_ifu;
    assign w_gnt_ifu   = w_can & ifu_cmd_valid & (~lsu_cmd_valid | w_force_ifu);
    assign w_gnt       = w_gnt_lsu | w_gnt_ifu;
    assign w_idle_cyc  = ~w_gnt & ~r_pend & ~w_any_valid;

    assign ifu_cmd_ready = w_gnt_ifu;
    assign lsu_cmd_ready = w_gnt_lsu;
    assign ram_ls        = w_ls;
    assign arb_busy      = r_pend;
    assign ifu_rsp_valid = r_pend & ~r_pend_lsu;
    assign lsu_rsp_valid = r_pend & r_pend_lsu;

    // Read data bypasses RAM output on the first response cycle, then replays the hold copy.
    assign w_rdata       = r_pend_wr ? '0 : (r_first ? ram_dout : r_hold);
    assign ifu_rsp_rdata = ifu_rsp_valid ? w_rdata : '0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? w_rdata : '0;

    // RAM strobes and payload are steered from the winning port in the grant cycle.
    always_comb begin
        ram_cs   = w_gnt;
        ram_we   = w_gnt_lsu & ~lsu_cmd_read;
        ram_addr = '0;
        ram_din  = '0;
        ram_wem  = '0;
        if (w_gnt_lsu) begin
            ram_addr = lsu_cmd_addr;
            ram_din  = lsu_cmd_wdata;
            if (!lsu_cmd_read) begin
                ram_wem = lsu_cmd_wmask;
            end
        end else if (w_gnt_ifu) begin
            ram_addr = ifu_cmd_addr;
        end
    end

    // Track the single outstanding access and capture its read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_lsu <= 1'b0;
            r_pend_wr  <= 1'b0;
            r_first    <= 1'b0;
            r_hold     <= '0;
        end else begin
            if (w_gnt) begin
                r_pend     <= 1'b1;
                r_pend_lsu <= w_gnt_lsu;
                r_pend_wr  <= w_gnt_lsu & ~lsu_cmd_read;
            end else if (w_rsp_hs) begin
                r_pend <= 1'b0;
            end
            r_first <= w_gnt;
            if (r_pend && r_first) begin
                r_hold <= ram_dout;
            end
        end
    end

    // Count LSU wins while IFU is kept waiting; IFU grant or IFU idle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!ifu_cmd_valid || w_gnt_ifu) begin
            r_starve <= '0;
        end else if (w_gnt_lsu && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + c_SW'(1);
        end
    end

    // Idle counter drives light-sleep; a request during sleep costs one wake cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
            r_wake <= 1'b0;
        end else begin
            if (!w_idle_cyc) begin
                r_idle <= '0;
            end else if (r_idle != c_IDLE_MAX) begin
                r_idle <= r_idle + c_IW'(1);
            end
            r_wake <= w_ls & w_any_valid;
        end
    end

endmodule
`default_nettype wire

// File: doc/e203_itcm_arb.md
E203_ITCM_ARB -- requirements
Module: e203_itcm_arb

Interface
REQ-001 SHALL have parameter AW, default 13: RAM word-address width.
REQ-002 SHALL have parameter DW, default 64: RAM data width.
REQ-003 SHALL have parameter MW, default 8: RAM byte-mask width (DW/8).
REQ-004 SHALL have parameter IDLE_LS, default 16: consecutive idle cycles before RAM light-sleep.
REQ-005 SHALL have parameter STARVE, default 4: maximum consecutive LSU grants while IFU waits.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 SHALL have the following ports:
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
  - ifu_cmd_valid / ifu_cmd_ready  in/out  1  IFU read request handshake
  - ifu_cmd_addr  in  AW  IFU word address
  - ifu_rsp_valid / ifu_rsp_ready  out/in  1  IFU response handshake
  - ifu_rsp_rdata  out  DW  IFU read data
  - lsu_cmd_valid / lsu_cmd_ready  in/out  1  LSU request handshake
  - lsu_cmd_read  in  1  1=read, 0=write
  - lsu_cmd_addr  in  AW  LSU address
  - lsu_cmd_wdata  in  DW  write data
  - lsu_cmd_wmask  in  MW  byte enables
  - lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake
  - lsu_rsp_rdata  out  DW  LSU read data
  - ram_cs, ram_we  out  1  RAM strobes
  - ram_addr  out  AW
  - ram_wem  out  MW
  - ram_din  out  DW
  - ram_dout  in  DW  valid the cycle after a read ram_cs
  - ram_ls  out  1  RAM light-sleep
  - arb_busy  out  1  response outstanding

Function
REQ-008 SHALL allow at most one outstanding RAM access globally.
REQ-009 SHALL grant a command only when ram_ls=0 and no response is pending, or the pending response handshakes in the same cycle (back-to-back, one access per cycle).
REQ-010 SHALL give LSU priority over IFU when both are valid.
REQ-011 SHALL count consecutive LSU grants while ifu_cmd_valid=1; when the count reaches STARVE, the next contended grant SHALL go to IFU and the count clears.
REQ-012 SHALL clear the starvation count on any IFU grant or when ifu_cmd_valid=0.
REQ-013 SHALL make cmd_ready combinational and asserted only for the winning port; ram_cs equals the accepted handshake in the same cycle.
REQ-014 SHALL drive, on a grant, ram_addr and ram_din/ram_wem from the winner; ram_we=1 only for an LSU write; IFU and LSU reads drive ram_wem=0.
REQ-015 SHALL assert the winner's rsp_valid the cycle after ram_cs and hold it until rsp_ready.
REQ-016 SHALL drive rsp_rdata directly from ram_dout in the first response cycle and capture ram_dout into a hold register at the same edge; later cycles present the hold register.
REQ-017 SHALL make the LSU write response rdata 0.
REQ-018 SHALL set arb_busy equal to the pending-response flag.
REQ-019 SHALL increment the idle counter on each cycle with ram_cs=0, no pending response and no command valid, saturating at IDLE_LS; any other cycle clears it.
REQ-020 SHALL assert ram_ls when the idle counter equals IDLE_LS.
REQ-021 SHALL deassert ram_ls in the cycle after any cmd_valid is seen while ram_ls=1 (one wake cycle, no grant that cycle); the grant follows no earlier than the next cycle.
REQ-022 SHALL never assert ram_cs while ram_ls=1.

Reset
REQ-023 SHALL, while rst=1, force all cmd_ready, rsp_valid, ram_cs, ram_we, ram_ls and arb_busy to 0.
REQ-024 SHALL reset the hold register, rsp_rdata, ram_addr, ram_din and ram_wem to 0, and both counters to 0.
REQ-025 SHALL discard any pending response on reset assertion mid-access; no response SHALL appear after release.

Verification
REQ-026 IFU read at addr 0x010, RAM returns 0xA5A5_0000_0000_0001, ifu_rsp_ready=1 -> ram_cs cycle N, ifu_rsp_valid cycle N+1 with that data; a second request is granted in N+1.
REQ-027 IFU read with ifu_rsp_ready held 0 for 3 cycles while ram_dout changes -> rdata stays the cycle-N+1 value, and no new grant occurs until accept.
REQ-028 LSU and IFU both valid continuously -> grant pattern L,L,L,L,I repeating; LSU write with wmask 0x0F gives ram_we=1, ram_wem=0x0F.
REQ-029 No traffic for 16 cycles -> ram_ls=1; IFU request then -> ram_ls=0 next cycle, grant the cycle after, and ram_cs=0 throughout sleep.
REQ-030 rst asserted the cycle after a grant -> rsp_valid=0 immediately; after release, no response and arb_busy=0.
